// File: rtl/sha_pad_pkg.sv
// Shared types and helpers for the SHA stream padder: FSM states, block geometry
// and the byte-valid mask used when a short final beat is written.
package sha_pad_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        PAD  = 3'd2,
        XTRA = 3'd3,
        EMIT = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [7:0] BB_256 = 8'd64;
    localparam logic [7:0] BB_512 = 8'd128;
    localparam logic [7:0] LB_256 = 8'd8;
    localparam logic [7:0] LB_512 = 8'd16;

    // Bit j is set when byte j (counting from the first, most significant byte) is valid.
    function automatic logic [15:0] byte_mask(input logic [7:0] nbytes);
        logic [15:0] m;
        for (int j = 0; j < 16; j++) begin
            m[j] = (8'(j) < nbytes);
        end
        return m;
    endfunction

endpackage

// File: rtl/sha_pad_blkbuf.sv
// 1024-bit block register, byte 0 in bits [1023:1016]. One cycle can clear it and
// then apply a masked beat write, a 0x80 marker and the length field together.
module sha_pad_blkbuf
    import sha_pad_pkg::*;
#(
    parameter int IN_W = 64,
    parameter int PW   = 4,
    parameter int BW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             beat_we,
    input  logic [PW-1:0]    beat_slot,
    input  logic [IN_W-1:0]  beat_data,
    input  logic [BW-1:0]    beat_bytes,
    input  logic             pad_we,
    input  logic [7:0]       pad_off,
    input  logic             len_we,
    input  logic             len_mode,
    input  logic [127:0]     len_val,
    output logic [1023:0]    blk
);
    logic [1023:0]   blk_r;
    logic [1023:0]   blk_n_s;
    logic [15:0]     mask_s;
    logic [IN_W-1:0] masked_s;

    // Next-state of the buffer: clear first, then the writes in fixed order.
    always_comb begin
        mask_s = byte_mask(8'(beat_bytes));
        for (int j = 0; j < IN_W / 8; j++) begin
            masked_s[IN_W-1-8*j -: 8] = mask_s[j] ? beat_data[IN_W-1-8*j -: 8] : 8'h00;
        end
        blk_n_s = clr ? 1024'h0 : blk_r;
        if (beat_we) begin
            blk_n_s[1023 - int'(beat_slot) * IN_W -: IN_W] = masked_s;
        end else begin
            blk_n_s = blk_n_s;
        end
        if (pad_we) begin
            blk_n_s[1023 - int'(pad_off) * 8 -: 8] = 8'h80;
        end else begin
            blk_n_s = blk_n_s;
        end
        // Length sits in the last LB bytes of a 64- or 128-byte block.
        if (len_we && len_mode) begin
            blk_n_s[127:0] = len_val;
        end else if (len_we) begin
            blk_n_s[575:512] = len_val[63:0];
        end else begin
            blk_n_s = blk_n_s;
        end
    end

    // Block storage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_r <= 1024'h0;
        end else begin
            blk_r <= blk_n_s;
        end
    end

    assign blk = blk_r;

endmodule

// File: rtl/sha_stream_padder.sv
// Streaming FIPS 180-4 padder: packs message beats into 512/1024-bit blocks,
// appends 0x80 and the bit length, and hands blocks out over valid/ready.
module sha_stream_padder
    import sha_pad_pkg::*;
#(
    parameter int IN_W  = 64,
    parameter int LEN_W = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_data,
    input  logic                     in_last,
    input  logic [$clog2(IN_W/8):0]  in_bytes,
    output logic                     blk_valid,
    input  logic                     blk_ready,
    output logic [1023:0]            blk_data,
    output logic                     blk_first,
    output logic                     blk_last,
    output logic                     busy,
    output logic                     err
);
    localparam int NB = IN_W / 8;
    localparam int BW = $clog2(NB) + 1;
    localparam int PW = $clog2(1024 / IN_W);
    localparam int SW = LEN_W + 1;

    state_t           state_r;
    state_t           ret_r;
    logic             mode_r;
    logic             pad_done_r;
    logic             first_r;
    logic             last_r;
    logic             in_ready_r;
    logic             blk_valid_r;
    logic             busy_r;
    logic             err_r;
    logic [PW-1:0]    ptr_r;
    logic [7:0]       off_r;
    logic [LEN_W-1:0] bit_cnt_r;

    logic             beat_acc_s;
    logic [BW-1:0]    nbytes_s;
    logic [7:0]       off_s;
    logic [SW-1:0]    sum_s;
    logic [7:0]       bb_s;
    logic [7:0]       lb_s;
    logic [PW-1:0]    ptr_max_s;
    logic             pad_now_s;
    logic             fits_s;
    logic [127:0]     len_s;
    logic             clr_s;
    logic             beat_we_s;
    logic             pad_we_s;
    logic             len_we_s;
    logic [7:0]       pad_off_s;
    logic [1023:0]    buf_s;

    assign beat_acc_s = in_ready_r && in_valid;
    assign nbytes_s   = in_last ? in_bytes : BW'(NB);
    assign off_s      = 8'(ptr_r) * 8'(NB) + 8'(nbytes_s);
    assign sum_s      = {1'b0, bit_cnt_r} + SW'({nbytes_s, 3'b000});
    assign bb_s       = mode_r ? BB_512 : BB_256;
    assign lb_s       = mode_r ? LB_512 : LB_256;
    assign ptr_max_s  = mode_r ? PW'(1024 / IN_W - 1) : PW'(512 / IN_W - 1);
    assign pad_now_s  = (off_r < bb_s);
    // The marker must leave room for the length field, or an extra block follows.
    assign fits_s     = (9'(off_r) + 9'd1) <= 9'(bb_s - lb_s);
    assign len_s      = 128'(bit_cnt_r);

    // Buffer write controls decoded from the current state.
    always_comb begin
        clr_s     = 1'b0;
        beat_we_s = 1'b0;
        pad_we_s  = 1'b0;
        len_we_s  = 1'b0;
        pad_off_s = 8'd0;
        case (state_r)
            IDLE: clr_s = start;
            FILL: beat_we_s = beat_acc_s;
            PAD: begin
                pad_we_s  = pad_now_s;
                pad_off_s = off_r;
                len_we_s  = (pad_done_r || pad_now_s) && fits_s;
            end
            XTRA: begin
                clr_s    = 1'b1;
                pad_we_s = !pad_done_r;
                len_we_s = 1'b1;
            end
            EMIT: clr_s = blk_ready;
            default: clr_s = 1'b0;
        endcase
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ret_r       <= IDLE;
            mode_r      <= 1'b0;
            pad_done_r  <= 1'b0;
            first_r     <= 1'b0;
            last_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            blk_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            ptr_r       <= '0;
            off_r       <= 8'd0;
            bit_cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r    <= FILL;
                        mode_r     <= mode;
                        bit_cnt_r  <= '0;
                        ptr_r      <= '0;
                        first_r    <= 1'b1;
                        last_r     <= 1'b0;
                        pad_done_r <= 1'b0;
                        err_r      <= 1'b0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                FILL: begin
                    if (beat_acc_s) begin
                        bit_cnt_r <= sum_s[LEN_W-1:0];
                        err_r     <= err_r | sum_s[LEN_W];
                        if (in_last) begin
                            off_r      <= off_s;
                            state_r    <= PAD;
                            in_ready_r <= 1'b0;
                        end else if (ptr_r == ptr_max_s) begin
                            ptr_r       <= '0;
                            ret_r       <= FILL;
                            state_r     <= EMIT;
                            in_ready_r  <= 1'b0;
                            blk_valid_r <= 1'b1;
                        end else begin
                            ptr_r <= ptr_r + PW'(1);
                        end
                    end
                end
                PAD: begin
                    pad_done_r  <= pad_done_r | pad_now_s;
                    state_r     <= EMIT;
                    blk_valid_r <= 1'b1;
                    last_r      <= len_we_s;
                    ret_r       <= len_we_s ? DONE : XTRA;
                end
                XTRA: begin
                    pad_done_r  <= 1'b1;
                    last_r      <= 1'b1;
                    ret_r       <= DONE;
                    state_r     <= EMIT;
                    blk_valid_r <= 1'b1;
                end
                EMIT: begin
                    if (blk_ready) begin
                        blk_valid_r <= 1'b0;
                        first_r     <= 1'b0;
                        case (ret_r)
                            FILL: begin
                                state_r    <= FILL;
                                in_ready_r <= 1'b1;
                            end
                            XTRA: state_r <= XTRA;
                            default: begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                                last_r  <= 1'b0;
                            end
                        endcase
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    sha_pad_blkbuf #(
        .IN_W (IN_W),
        .PW   (PW),
        .BW   (BW)
    ) u_blkbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr_s),
        .beat_we    (beat_we_s),
        .beat_slot  (ptr_r),
        .beat_data  (in_data),
        .beat_bytes (nbytes_s),
        .pad_we     (pad_we_s),
        .pad_off    (pad_off_s),
        .len_we     (len_we_s),
        .len_mode   (mode_r),
        .len_val    (len_s),
        .blk        (buf_s)
    );

    assign in_ready  = in_ready_r;
    assign blk_valid = blk_valid_r;
    assign blk_first = first_r;
    assign blk_last  = last_r;
    assign busy      = busy_r;
    assign err       = err_r;
    assign blk_data  = mode_r ? buf_s : {512'h0, buf_s[1023:512]};

endmodule

// File: tb/tb_sha_stream_padder.sv
// Directed bench for sha_stream_padder: table of message lengths checked against a
// byte-level padding model, plus hand-written corner sequences.
module tb_sha_stream_padder;
    localparam int IN_W  = 64;
    localparam int LEN_W = 128;
    localparam int NB    = IN_W / 8;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              start     = 1'b0;
    logic              mode      = 1'b0;
    logic              in_valid  = 1'b0;
    logic              in_last   = 1'b0;
    logic              blk_ready = 1'b0;
    logic [IN_W-1:0]   in_data   = '0;
    logic [3:0]        in_bytes  = 4'd0;
    logic              in_ready;
    logic              blk_valid;
    logic              blk_first;
    logic              blk_last;
    logic              busy;
    logic              err;
    logic [1023:0]     blk_data;

    int checks = 0;
    int errors = 0;
    logic [7:0]    msg [0:255];
    logic [1023:0] got_data  [0:3];
    logic          got_first [0:3];
    logic          got_last  [0:3];
    int            got_n;

    typedef struct {
        logic md;
        int   len;
        int   nblk;
    } vec_t;
    vec_t vecs [0:10];

    always #5 clk = ~clk;

    sha_stream_padder #(.IN_W(IN_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .busy      (busy),
        .err       (err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_blk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        int bad;
        checks++;
        if (act !== exp) begin
            errors++;
            bad = 0;
            for (int i = 127; i >= 0; i--) begin
                if (act[1023-8*i -: 8] !== exp[1023-8*i -: 8]) bad = i;
            end
            $display("FAIL %s: block byte %0d got %02h expected %02h", name, bad,
                     act[1023-8*bad -: 8], exp[1023-8*bad -: 8]);
        end
    endtask

    // Padded byte stream built from scratch, then sliced into block k.
    function automatic logic [1023:0] ref_block(input logic md, input int len, input int k);
        int bb = md ? 128 : 64;
        int lb = md ? 16 : 8;
        int total = ((len + 1 + lb + bb - 1) / bb) * bb;
        longint bits = longint'(len) * 8;
        logic [1023:0] r = '0;
        int p;
        int sh;
        logic [7:0] b;
        for (int j = 0; j < bb; j++) begin
            p = k * bb + j;
            if (p < len) b = msg[p];
            else if (p == len) b = 8'h80;
            else if (p >= total - lb) begin
                sh = 8 * (total - 1 - p);
                b = (sh < 64) ? 8'(bits >> sh) : 8'h00;
            end else b = 8'h00;
            r[bb*8-1-8*j -: 8] = b;
        end
        return r;
    endfunction

    task automatic run_msg(input logic md, input int len, input int stall, input string tag);
        int nbeats;
        int beat;
        int cyc;
        int stall_left;
        logic done;
        logic acc_beat;
        logic acc_blk;
        logic [1023:0] held;
        nbeats = (len == 0) ? 1 : (len + NB - 1) / NB;
        beat = 0; cyc = 0; got_n = 0; done = 1'b0; stall_left = stall; held = '0;
        @(negedge clk);
        mode = md; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = ~md;
        while (!done && cyc < 1000) begin
            if (beat < nbeats) begin
                in_valid = 1'b1;
                in_last  = (beat == nbeats - 1);
                in_bytes = in_last ? 4'(len - beat * NB) : 4'(NB);
                for (int j = 0; j < NB; j++) begin
                    in_data[IN_W-1-8*j -: 8] = (beat * NB + j < len) ? msg[beat*NB+j] : 8'hEE;
                end
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            blk_ready = 1'b1;
            start = 1'b0;
            if (blk_valid && stall_left > 0) begin
                blk_ready = 1'b0;
                start = 1'b1;
                if (stall_left < stall) begin
                    chk_blk({tag, " held data"}, blk_data, held);
                    chk({tag, " in_ready in emit"}, 128'(in_ready), 128'd0);
                end
                held = blk_data;
                stall_left--;
            end
            acc_beat = in_valid && in_ready;
            acc_blk  = blk_valid && blk_ready;
            if (acc_blk && got_n < 4) begin
                got_data[got_n]  = blk_data;
                got_first[got_n] = blk_first;
                got_last[got_n]  = blk_last;
                got_n++;
            end
            @(posedge clk);
            if (acc_beat) beat++;
            #1;
            if (acc_blk && !busy) done = 1'b1;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0; start = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d blocks, busy %0b", tag, got_n, busy);
        end
    endtask

    task automatic check_model(input logic md, input int len, input int nblk, input string tag);
        chk({tag, " block count"}, 128'(got_n), 128'(nblk));
        for (int k = 0; k < got_n && k < nblk; k++) begin
            chk_blk($sformatf("%s blk%0d data", tag, k), got_data[k], ref_block(md, len, k));
            chk($sformatf("%s blk%0d first", tag, k), 128'(got_first[k]), 128'(k == 0));
            chk($sformatf("%s blk%0d last", tag, k), 128'(got_last[k]), 128'(k == nblk - 1));
        end
        chk({tag, " busy after"}, 128'(busy), 128'd0);
        chk({tag, " err"}, 128'(err), 128'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b0,   3, 1};
        vecs[1]  = '{1'b1,   0, 1};
        vecs[2]  = '{1'b0,  55, 1};
        vecs[3]  = '{1'b0,  56, 2};
        vecs[4]  = '{1'b0,  63, 2};
        vecs[5]  = '{1'b0,  64, 2};
        vecs[6]  = '{1'b0, 120, 3};
        vecs[7]  = '{1'b0,  13, 1};
        vecs[8]  = '{1'b1, 111, 1};
        vecs[9]  = '{1'b1, 112, 2};
        vecs[10] = '{1'b1, 128, 2};

        repeat (3) @(negedge clk);
        chk("reset in_ready", 128'(in_ready), 128'd0);
        chk("reset blk_valid", 128'(blk_valid), 128'd0);
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset err", 128'(err), 128'd0);
        chk_blk("reset blk_data", blk_data, 1024'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // "abc" in SHA-256 mode.
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        run_msg(1'b0, 3, 0, "abc");
        chk("abc count", 128'(got_n), 128'd1);
        chk_blk("abc block", got_data[0], {512'h0, 32'h61626380, 416'h0, 64'h18});
        chk("abc first", 128'(got_first[0]), 128'd1);
        chk("abc last", 128'(got_last[0]), 128'd1);

        for (int i = 0; i < 256; i++) msg[i] = 8'(i * 13 + 1);

        for (int v = 0; v < 11; v++) begin
            run_msg(vecs[v].md, vecs[v].len, 0, $sformatf("vec%0d", v));
            check_model(vecs[v].md, vecs[v].len, vecs[v].nblk, $sformatf("vec%0d", v));
        end

        run_msg(1'b1, 0, 0, "empty");
        chk_blk("empty block", got_data[0], {8'h80, 1016'h0});
        run_msg(1'b0, 56, 0, "m56");
        chk("m56 blk0 last", 128'(got_last[0]), 128'd0);
        chk_blk("m56 blk1", got_data[1], {512'h0, 448'h0, 64'h1C0});
        run_msg(1'b0, 64, 0, "m64");
        chk_blk("m64 blk1", got_data[1], {512'h0, 8'h80, 440'h0, 64'h200});
        run_msg(1'b1, 112, 0, "m112");
        chk("m112 length", got_data[1][127:0], 128'h380);

        // Backpressure with start pulses while busy.
        run_msg(1'b0, 20, 5, "bp");
        check_model(1'b0, 20, 1, "bp");

        // Reset in the middle of FILL.
        @(negedge clk);
        mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_last = 1'b0; in_data = 64'h0102030405060708;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst mid in_ready", 128'(in_ready), 128'd0);
        chk("rst mid blk_valid", 128'(blk_valid), 128'd0);
        chk("rst mid busy", 128'(busy), 128'd0);
        chk("rst mid err", 128'(err), 128'd0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post rst blk_valid", 128'(blk_valid), 128'd0);
        end
        chk_blk("post rst blk_data", blk_data, 1024'h0);
        run_msg(1'b1, 112, 0, "after rst");
        check_model(1'b1, 112, 2, "after rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
